// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for the scoreboarded register file
package regfile_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NREAD = 2;
  function automatic logic is_zero(input int unsigned addr);
    return addr == 0;
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port with zero register, write bypass and hazard flag
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic [AW-1:0]               addr,
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [DEPTH-1:0]            busy,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_busy
);
  logic byp;
  assign byp = wr_en && wr_addr == addr;
  assign rd_data = is_zero(32'(addr)) ? '0 : byp ? wr_data : regs[addr];
  assign rd_busy = busy[addr] && !byp;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with write-through bypass and per-register pending-write scoreboard
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NREAD = DEF_NREAD,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = cnt_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_addr,
  output logic                   issue_ok,
  output logic [AW:0]            pending,
  output logic                   err
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0] busy, busy_nxt;
  logic wr_live, clr, acc;
  assign wr_live = wr_en && !is_zero(32'(wr_addr));
  assign clr = wr_live && busy[wr_addr];
  assign issue_ok = is_zero(32'(issue_addr)) || !busy[issue_addr] || (wr_en && wr_addr == issue_addr);
  assign acc = issue_en && issue_ok && !is_zero(32'(issue_addr));
  // set after clear so a same-address issue leaves the new producer busy
  always_comb begin
    busy_nxt = busy;
    if (wr_live) busy_nxt[wr_addr] = 1'b0;
    if (acc) busy_nxt[issue_addr] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
      busy <= '0;
      pending <= '0;
      err <= 1'b0;
    end else begin
      if (wr_live) mem[wr_addr] <= wr_data;
      busy <= busy_nxt;
      pending <= pending + PW'(acc) - PW'(clr);
      if ((wr_live && !busy[wr_addr]) || (issue_en && !issue_ok)) err <= 1'b1;
    end
  end
  for (genvar i = 0; i < NREAD; i++) begin : g_rp
    regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rp (
      .addr   (rd_addr[i*AW +: AW]),
      .regs   (mem),
      .busy   (busy),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_data(rd_data[i*WIDTH +: WIDTH]),
      .rd_busy(rd_busy[i])
    );
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and randomized checks against a behavioural register/scoreboard model
module tb_regfile_scoreboard;
  logic clk = 0;
  always #5 clk = ~clk;

  logic rst, wr_en, issue_en, issue_ok, err;
  logic [4:0] ra0, ra1, wr_addr, issue_addr;
  logic [9:0] rd_addr;
  logic [63:0] rd_data;
  logic [1:0] rd_busy;
  logic [31:0] wr_data;
  logic [5:0] pending;
  assign rd_addr = {ra1, ra0};

  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
    .issue_addr(issue_addr), .issue_ok(issue_ok), .pending(pending), .err(err)
  );

  logic p_rst, p_wr_en, p_issue_en, p_issue_ok, p_err;
  logic [11:0] p_rd_addr;
  logic [63:0] p_rd_data;
  logic [3:0] p_rd_busy, p_pending;
  logic [2:0] p_wr_addr, p_issue_addr;
  logic [15:0] p_wr_data;

  regfile_scoreboard #(.WIDTH(16), .DEPTH(8), .NREAD(4)) dut_p (
    .clk(clk), .rst(p_rst), .rd_addr(p_rd_addr), .rd_data(p_rd_data), .rd_busy(p_rd_busy),
    .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data), .issue_en(p_issue_en),
    .issue_addr(p_issue_addr), .issue_ok(p_issue_ok), .pending(p_pending), .err(p_err)
  );

  int checks = 0, errors = 0;
  logic [31:0] ref_mem [32];
  bit ref_busy [32];
  bit ref_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 0) return 0;
    if (wr_en && wr_addr == a) return wr_data;
    return ref_mem[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    return ref_busy[a] && !(wr_en && wr_addr == a);
  endfunction

  function automatic logic [31:0] m_pend();
    int s = 0;
    foreach (ref_busy[k]) s += int'(ref_busy[k]);
    return 32'(s);
  endfunction

  task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic ie, input logic [4:0] ia, input logic [4:0] a0, input logic [4:0] a1);
    logic ok;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    issue_en = ie; issue_addr = ia; ra0 = a0; ra1 = a1;
    #1;
    ok = ia == 0 || !ref_busy[ia] || (we && wa == ia);
    chk("rd_data0", rd_data[31:0], m_rd(a0));
    chk("rd_data1", rd_data[63:32], m_rd(a1));
    chk("rd_busy0", 32'(rd_busy[0]), 32'(m_busy(a0)));
    chk("rd_busy1", 32'(rd_busy[1]), 32'(m_busy(a1)));
    chk("issue_ok", 32'(issue_ok), 32'(ok));
    @(posedge clk);
    if (r) begin
      foreach (ref_mem[k]) begin ref_mem[k] = 0; ref_busy[k] = 0; end
      ref_err = 0;
    end else begin
      if (we && wa != 0) begin
        if (!ref_busy[wa]) ref_err = 1;
        ref_mem[wa] = wd;
        ref_busy[wa] = 0;
      end
      if (ie) begin
        if (!ok) ref_err = 1;
        else if (ia != 0) ref_busy[ia] = 1;
      end
    end
    @(negedge clk);
    chk("pending", 32'(pending), m_pend());
    chk("err", 32'(err), 32'(ref_err));
  endtask

  initial begin
    rst = 1; wr_en = 0; issue_en = 0; wr_addr = 0; issue_addr = 0; wr_data = 0; ra0 = 0; ra1 = 0;
    p_rst = 1; p_wr_en = 0; p_issue_en = 0; p_wr_addr = 0; p_issue_addr = 0; p_wr_data = 0; p_rd_addr = 0;
    foreach (ref_mem[k]) begin ref_mem[k] = 'x; ref_busy[k] = 0; end
    ref_err = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 3, 17);
    chk("reset_pending", 32'(pending), 0);
    chk("reset_err", 32'(err), 0);
    chk("reset_rd", rd_data[31:0], 0);
    // write with same-cycle bypass, then write to register 0
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
    wr_en = 0; #1;
    chk("stored_5", rd_data[31:0], 32'hDEADBEEF);
    step(0, 1, 0, 32'h1234, 0, 0, 0, 5);
    chk("reg0_zero", rd_data[31:0], 0);
    // scoreboard issue / writeback
    step(0, 0, 0, 0, 1, 7, 7, 0);
    issue_en = 0; #1;
    chk("busy_7", 32'(rd_busy[0]), 1);
    chk("pending_1", 32'(pending), 1);
    step(0, 1, 7, 32'h55, 0, 0, 7, 7);
    chk("pending_0", 32'(pending), 0);
    // double issue without writeback
    step(0, 0, 0, 0, 1, 7, 7, 0);
    step(0, 0, 0, 0, 1, 7, 7, 0);
    chk("dbl_err", 32'(err), 1);
    chk("dbl_pending", 32'(pending), 1);
    step(0, 1, 7, 32'h77, 0, 0, 7, 0);
    // writeback and issue to busy reg 9 in one cycle
    step(0, 0, 0, 0, 1, 9, 9, 0);
    step(0, 1, 9, 32'hCAFE0009, 1, 9, 9, 0);
    wr_en = 0; issue_en = 0; #1;
    chk("wi_busy9", 32'(rd_busy[0]), 1);
    chk("wi_data9", rd_data[31:0], 32'hCAFE0009);
    // reset mid-flight
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 3, 4);
    step(0, 0, 0, 0, 1, 4, 3, 4);
    step(0, 0, 0, 0, 1, 6, 6, 0);
    chk("mid_pending3", 32'(pending), 3);
    step(1, 1, 3, 32'h1, 1, 8, 3, 4);
    chk("mid_pending0", 32'(pending), 0);
    step(0, 1, 3, 32'h33, 0, 0, 3, 0);
    chk("mid_err", 32'(err), 1);
    // randomized traffic concentrated on a few registers to provoke hazards
    for (int n = 0; n < 600; n++)
      step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)), 5'($urandom_range(0, 31)));
    // parameter sweep instance: WIDTH=16, DEPTH=8, NREAD=4
    p_rst = 0;
    for (int i = 1; i < 8; i++) begin
      p_wr_en = 1; p_wr_addr = 3'(i); p_wr_data = 16'(i * 16'h1111);
      @(negedge clk);
    end
    p_wr_en = 0;
    p_rd_addr = {3'd7, 3'd0, 3'd2, 3'd5};
    #1;
    chk("p_rd0", 32'(p_rd_data[15:0]), 32'h5555);
    chk("p_rd1", 32'(p_rd_data[31:16]), 32'h2222);
    chk("p_rd2", 32'(p_rd_data[47:32]), 0);
    chk("p_rd3", 32'(p_rd_data[63:48]), 32'h7777);
    for (int i = 1; i < 8; i++) begin
      p_issue_en = 1; p_issue_addr = 3'(i);
      @(negedge clk);
    end
    p_issue_en = 0;
    chk("p_pending7", 32'(p_pending), 7);
    p_issue_addr = 0; #1;
    chk("p_ok0", 32'(p_issue_ok), 1);
    p_issue_addr = 3; #1;
    chk("p_ok3", 32'(p_issue_ok), 0);
    chk("p_busy", 32'(p_rd_busy), 32'b1011);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised successor to the single-cycle register file: DEPTH×WIDTH storage with NREAD combinational read ports, one synchronous write port, a hardwired zero register, write-through bypass, and a per-register pending-write scoreboard. It sits between decode and execute/writeback in the multi-cycle and pipelined datapath variants. It gives issue logic hazard information (source busy, destination free) and counts outstanding writes.

## Interface
- WIDTH, 32: data width of each register.
- DEPTH, 32: number of registers; power of two, at least 2.
- NREAD, 2: number of read ports, at least 1.
- AW, $clog2(DEPTH): address width (derived, not overridden).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- rd_addr  in  NREAD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NREAD*WIDTH  packed read data, combinational.
- rd_busy  out  NREAD  source i has an outstanding write not yet written back.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  WIDTH  writeback data.
- issue_en  in  1  reserve a destination; marks it busy.
- issue_addr  in  AW  destination being reserved.
- issue_ok  out  1  combinational; an issue this cycle would be accepted.
- pending  out  AW+1  number of busy registers.
- err  out  1  sticky; set by a rejected issue or a writeback to a non-busy nonzero register.

## Operation
- Register 0 always reads 0. Writes to register 0 are discarded. Register 0 is never busy. Issue to register 0 is always accepted and changes nothing.
- Reads are combinational:
  - rd_data[i] = 0 if rd_addr[i]==0.
  - Otherwise rd_data[i] = wr_data if wr_en && wr_addr==rd_addr[i] (bypass).
  - Otherwise rd_data[i] = the stored value.
- rd_busy[i] = busy[rd_addr[i]] && !(wr_en && wr_addr==rd_addr[i]). A same-cycle writeback resolves the hazard.
- issue_ok = issue_addr==0 || !busy[issue_addr] || (wr_en && wr_addr==issue_addr).
- Each register has one busy bit. There is no WAW queueing: a second issue to a busy register is rejected.
- At the clock edge, with rst low:
  - wr_en && wr_addr!=0: store wr_data and clear busy[wr_addr].
  - wr_en to a nonzero register that is not busy: still store the data, but set err.
  - issue_en && issue_ok && issue_addr!=0: set busy[issue_addr].
  - Issue and writeback to the same address in the same cycle: data is stored and busy ends at 1 (new producer wins).
  - issue_en && !issue_ok: busy is unchanged and err is set.
- pending equals the population count of the busy bits. It is kept as a registered counter and updated by (+1 issue accepted) + (−1 busy cleared), net per cycle. It never wraps; its maximum is DEPTH−1.
- err clears only on rst.

## Timing
- Read latency is 0 cycles (combinational). Write-to-storage latency is 1 edge. The bypass makes same-cycle write data visible.
- busy, pending and err update on the rising edge and are visible in the cycle after.
- rst high at an edge has these effects:
  - All registers go to 0.
  - All busy bits clear, so pending=0 and err=0.
  - rd_data reads 0 on every port, except through the bypass.
  - rd_busy=0.
  - issue_ok=1.
- rst dominates any wr_en or issue_en in the same cycle; those operations are lost.
- A reset in the middle of outstanding writes drops all reservations. A later writeback to a formerly busy register sets err.

## Structure
- Package regfile_pkg holds:
  - default WIDTH/DEPTH/NREAD localparams;
  - a function for the zero-register check;
  - a popcount-width helper.
- Sub-module regfile_read_port, instantiated NREAD times via generate: address in, stored-value array slice, bypass inputs and busy vector in → rd_data and rd_busy out.
- Storage, busy vector, pending counter and err live in the top module.

## Test plan
- Reset then read: rst for 2 cycles → all ports read 0, rd_busy=0, pending=0, issue_ok=1, err=0.
- Write/read with bypass: wr_en, addr 5, data 0xDEADBEEF, with rd_addr[0]=5 in the same cycle → rd_data[0]=0xDEADBEEF in that cycle and after. A write of 0x1234 to reg 0 → reg 0 still reads 0.
- Scoreboard: issue reg 7 → next cycle rd_busy=1 for reg 7 and pending=1. Writeback 0x55 to reg 7 → rd_busy drops in that cycle, then pending=0.
- Conflicts:
  - Issue reg 7 twice without a writeback → issue_ok=0 on the second attempt, then err=1 and pending stays 1.
  - Writeback and issue to reg 9 in the same cycle while it is busy → busy stays 1 and the data is stored.
- Reset mid-flight: issue regs 3, 4, 6 (pending=3), then rst → pending=0. A later writeback to reg 3 → err=1.
- Parameter sweep: DEPTH=8, NREAD=4, WIDTH=16 → 4 ports read independently, pending reaches 7 after issuing regs 1–7, and issue_ok=1 for reg 0.
